// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the RAM port arbiter
package mem_port_arbiter_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  // Size code 3 is treated as a word access.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_ld_ext.sv
// rtl/mem_port_arbiter_ld_ext.sv - sign/zero extender for assembled load data
module mem_ld_ext
  import mem_port_arbiter_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] ext
);

  always_comb begin
    case (size)
      SZ_BYTE: ext = {{24{sext & data[7]}}, data[7:0]};
      SZ_HALF: ext = {{16{sext & data[15]}}, data[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the byte-wide RAM port between IF and MEM
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              flush_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_sext_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done_o,
  output logic              stall_req_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  logic [1:0]        state;
  logic [2:0]        cnt;
  logic [2:0]        nbytes;
  logic              owner;
  logic              we;
  logic              sext;
  logic [1:0]        size;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata;
  logic [31:0]       asm_data;
  logic [31:0]       if_data_q;
  logic [31:0]       mem_rdata_q;
  logic [31:0]       ld_ext;
  logic              beat_live;
  logic [1:0]        byte_idx;

  mem_ld_ext u_ld_ext (
    .data (asm_data),
    .size (size),
    .sext (sext),
    .ext  (ld_ext)
  );

  // Read data trails its address by one cycle, so cnt=k lands byte k-1.
  assign byte_idx  = cnt[1:0] - 2'd1;
  assign beat_live = (state == ST_XFER) && (cnt < nbytes);

  assign ram_addr_o = beat_live ? base + ADDR_W'(cnt) : '0;
  assign ram_wr_o   = beat_live && we;
  assign ram_dout_o = (beat_live && we) ? wdata[{cnt[1:0], 3'b000} +: 8] : 8'h00;

  assign if_done_o   = (state == ST_DONE) && (owner == OWN_IF);
  assign mem_done_o  = (state == ST_DONE) && (owner == OWN_MEM);
  assign if_data_o   = if_done_o ? asm_data : if_data_q;
  assign mem_rdata_o = (mem_done_o && !we) ? ld_ext : mem_rdata_q;
  assign stall_req_o = (mem_req_i & ~mem_done_o) | (if_req_i & ~if_done_o);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= 3'd0;
      nbytes      <= 3'd0;
      owner       <= OWN_IF;
      we          <= 1'b0;
      sext        <= 1'b0;
      size        <= SZ_BYTE;
      base        <= '0;
      wdata       <= 32'h0;
      asm_data    <= 32'h0;
      if_data_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt      <= 3'd0;
          asm_data <= 32'h0;
          // The MEM-stage instruction is older, so it wins a tie.
          if (mem_req_i) begin
            state  <= ST_XFER;
            owner  <= OWN_MEM;
            base   <= mem_addr_i;
            nbytes <= size_bytes(mem_size_i);
            size   <= mem_size_i;
            we     <= mem_we_i;
            sext   <= mem_sext_i;
            wdata  <= mem_wdata_i;
          end else if (if_req_i && !flush_i) begin
            state  <= ST_XFER;
            owner  <= OWN_IF;
            base   <= if_addr_i;
            nbytes <= 3'd4;
            size   <= SZ_WORD;
            we     <= 1'b0;
            sext   <= 1'b0;
          end
        end
        ST_XFER: begin
          if (owner == OWN_IF && flush_i) begin
            state <= ST_IDLE;
          end else if (we) begin
            if (cnt == nbytes - 3'd1) state <= ST_DONE;
            else                      cnt   <= cnt + 3'd1;
          end else begin
            if (cnt != 3'd0) asm_data[{byte_idx, 3'b000} +: 8] <= ram_din_i;
            if (cnt == nbytes) state <= ST_DONE;
            else               cnt   <= cnt + 3'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          if (owner == OWN_IF) if_data_q   <= asm_data;
          else if (!we)        mem_rdata_q <= ld_ext;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
